wb_stage_reg: RTL and testbench
===============================

# wb_stage_reg

Parametrised, registered writeback stage for the pipelined OTTER core. Each cycle it selects one of `NUM_SRC` result sources, aligns and sign/zero-extends load data, and registers the write data, register address and write enable into a single output slot. The slot uses a valid/ready handshake toward the register file. The registered result also drives a forwarding port for the hazard unit.

## Interface

**Parameters**
- `WIDTH`, 32: data width in bits; a multiple of 16.
- `NUM_SRC`, 4: number of selectable result sources; minimum 2.
- `SEL_W`, `$clog2(NUM_SRC)`: width of `RF_WR_SEL`.
- `ADDR_W`, 5: register address width.
- `LOAD_SRC`, 1: source index that carries raw memory read data and receives alignment/extension.

**Ports**
- `CLK`, in, 1: clock; all state updates on the rising edge.
- `RST`, in, 1: synchronous, active-high reset.
- `IN_VALID`, in, 1: upstream presents a result.
- `IN_READY`, out, 1: stage can accept this cycle.
- `SRC`, in, `NUM_SRC*WIDTH`: packed sources; source i is `SRC[i*WIDTH +: WIDTH]`.
- `RF_WR_SEL`, in, `SEL_W`: source select.
- `MEM_SIZE`, in, 2: load size; 0 = byte, 1 = half, 2 = word, 3 = reserved.
- `MEM_SIGN`, in, 1: 1 = sign-extend, 0 = zero-extend.
- `BYTE_OFF`, in, 2: low address bits of the load.
- `WA_IN`, in, `ADDR_W`: destination register.
- `WE_IN`, in, 1: instruction writes a register.
- `FLUSH`, in, 1: kill the held and incoming result.
- `OUT_VALID`, out, 1: the slot holds a result.
- `OUT_READY`, in, 1: register file consumes the slot.
- `WD`, out, `WIDTH`: registered write data.
- `WA`, out, `ADDR_W`: registered write address.
- `WE`, out, 1: registered write enable.
- `FWD_VALID`, out, 1: equals `OUT_VALID && WE`.

## Operation
- **Accept condition:** `IN_READY = !OUT_VALID || OUT_READY`, combinational. A transfer-in occurs when `IN_VALID && IN_READY`.
- **Source select:** picks `SRC[RF_WR_SEL]`. If `RF_WR_SEL >= NUM_SRC`, the selected data is 0.
- **Load alignment:** applies only when `RF_WR_SEL == LOAD_SRC`.
  - Byte: takes byte `BYTE_OFF`.
  - Half: takes halfword `BYTE_OFF[1]`; `BYTE_OFF[0]` is ignored.
  - Word and reserved size 3: data passes through unchanged; offset is ignored.
  - Byte and half results are extended to `WIDTH` per `MEM_SIGN`.
- **x0 suppression:** the captured `WE` is `WE_IN && (WA_IN != 0)`. `WD` and `WA` are still captured when the write is suppressed.
- **Slot state:** two states, EMPTY (`OUT_VALID=0`) and FULL (`OUT_VALID=1`).
  - EMPTY + transfer-in: go to FULL.
  - FULL + `OUT_READY` + transfer-in: stay FULL with the new contents.
  - FULL + `OUT_READY` with no transfer-in: go to EMPTY.
  - FULL + `!OUT_READY`: hold all outputs stable.
- **Priority:** `RST` > `FLUSH` > handshake.
  - `FLUSH` forces EMPTY on the next edge, regardless of `IN_VALID` or `OUT_READY`.
  - `WD`, `WA` and `WE` are cleared to 0 on `FLUSH`.
- **Register-file write:** occurs exactly on a cycle where `OUT_VALID && OUT_READY && WE`.

## Timing
- **Reset values:** `OUT_VALID`=0, `WD`=0, `WA`=0, `WE`=0, `FWD_VALID`=0. `IN_READY`=1 during and after reset.
- **Latency:** a result accepted at edge N appears on `WD`/`WA`/`WE` and `OUT_VALID` after edge N. It is visible on `FWD_*` in the same cycle.
- **Throughput:** one result per cycle while `OUT_READY` is held high.
- **Back-pressure:** `IN_READY` falls in the same cycle that `OUT_VALID && !OUT_READY`. There is no bubble on release.
- **Combinational paths:** `IN_READY` depends combinationally on `OUT_READY`. No other combinational input-to-output path exists.
- **Reset mid-stall:** the held result is discarded and no register-file write occurs.

## Structure
- **Shared package `otter_wb_pkg`:**
  - Size encodings `MEM_BYTE`=0, `MEM_HALF`=1, `MEM_WORD`=2.
  - Select constants `WB_PC4`=0, `WB_MEM`=1, `WB_CSR`=2, `WB_ALU`=3, kept consistent with the existing `RF_WR_SEL` encoding.
- **Sub-module `load_align`:** combinational; inputs raw word, `MEM_SIZE`, `MEM_SIGN`, `BYTE_OFF`; output extended data.
- **Top-level contents:** the select mux, the x0 logic and the single output register.

## Test plan
- **Reset:** assert `RST` 2 cycles with `IN_VALID`=1 → `OUT_VALID`=0, `WD`=0, `WE`=0. After release, `IN_READY`=1.
- **Source select:** SRC = {0x3, 0x2, 0x1, 0x0} (index 3..0), `RF_WR_SEL`=2, `WA_IN`=5, `WE_IN`=1 → next cycle `WD`=0x2, `WA`=5, `WE`=1, `FWD_VALID`=1. A second run with `WA_IN`=0 → `WE`=0, `FWD_VALID`=0.
- **Load extension:** raw 0x80FF7F01 on `LOAD_SRC`:
  - byte, off 3, signed → 0xFFFFFF80.
  - byte, off 1, unsigned → 0x0000007F.
  - half, off 2, signed → 0xFFFF80FF.
  - half, off 3 → same as off 2.
  - size 3 → 0x80FF7F01.
- **Back-pressure:** `OUT_READY`=0 for 3 cycles with a held result → `WD` stable, `IN_READY`=0. Raise `OUT_READY` together with `IN_VALID` → new result loaded on the next edge, no EMPTY cycle.
- **Flush:** `FLUSH` with FULL slot, `IN_VALID`=1 and `OUT_READY`=0 → next cycle `OUT_VALID`=0 and `WD`=0.
- **Out-of-range select:** `NUM_SRC`=3, `RF_WR_SEL`=3 → `WD`=0. Check throughput with `OUT_READY` tied high and 8 back-to-back inputs → 8 outputs on consecutive cycles.

Source files
------------

// File: rtl/otter_wb_pkg.sv
// Shared writeback definitions for the OTTER pipeline.
// - Load size encodings (MEM_SIZE field of the load instruction).
// - RF_WR_SEL source indices, matching the existing decoder encoding.
// - Output slot state encoding used by wb_stage_reg.
package otter_wb_pkg;

    // Load sizes; encoding 3 is reserved and treated like a word.
    localparam logic [1:0] MEM_BYTE = 2'd0;
    localparam logic [1:0] MEM_HALF = 2'd1;
    localparam logic [1:0] MEM_WORD = 2'd2;

    // Writeback source indices.
    localparam int WB_PC4 = 0;
    localparam int WB_MEM = 1;
    localparam int WB_CSR = 2;
    localparam int WB_ALU = 3;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/load_align.sv
// Load data alignment and extension (combinational).
// Ports:
//   raw       - memory read word
//   mem_size  - 0 byte, 1 half, 2 word, 3 reserved (passes through)
//   mem_sign  - 1 sign-extend, 0 zero-extend
//   byte_off  - low address bits of the load
//   data      - aligned, extended result
module load_align
    import otter_wb_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] raw,
    input  logic [1:0]       mem_size,
    input  logic             mem_sign,
    input  logic [1:0]       byte_off,
    output logic [WIDTH-1:0] data
);

    logic [7:0]  byte_val;
    logic [15:0] half_val;

    // Byte lane = byte_off, half lane = byte_off[1]; byte_off[0] is
    // meaningless for halfwords and is dropped.
    assign byte_val = raw[{byte_off, 3'b000} +: 8];
    assign half_val = raw[{byte_off[1], 4'b0000} +: 16];

    always_comb begin
        data = raw;
        case (mem_size)
            MEM_BYTE: data = {{(WIDTH-8){mem_sign & byte_val[7]}}, byte_val};
            MEM_HALF: data = {{(WIDTH-16){mem_sign & half_val[15]}}, half_val};
            default:  data = raw;
        endcase
    end

endmodule

// File: rtl/wb_stage_reg.sv
// Registered writeback stage: source select, load alignment, x0 write
// suppression and a single valid/ready output slot toward the register
// file. The registered slot also feeds the hazard unit forwarding port.
// Ports:
//   CLK, RST            - clock, synchronous active-high reset
//   IN_VALID/IN_READY   - upstream handshake
//   SRC, RF_WR_SEL      - packed result sources and select
//   MEM_SIZE/SIGN, BYTE_OFF - load alignment controls
//   WA_IN, WE_IN        - destination register and write intent
//   FLUSH               - kill held and incoming result
//   OUT_VALID/OUT_READY - register file handshake
//   WD, WA, WE          - registered write data/address/enable
//   FWD_VALID           - slot holds a real register write
module wb_stage_reg
    import otter_wb_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int NUM_SRC  = 4,
    parameter int SEL_W    = $clog2(NUM_SRC),
    parameter int ADDR_W   = 5,
    parameter int LOAD_SRC = WB_MEM
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     IN_VALID,
    output logic                     IN_READY,
    input  logic [NUM_SRC*WIDTH-1:0] SRC,
    input  logic [SEL_W-1:0]         RF_WR_SEL,
    input  logic [1:0]               MEM_SIZE,
    input  logic                     MEM_SIGN,
    input  logic [1:0]               BYTE_OFF,
    input  logic [ADDR_W-1:0]        WA_IN,
    input  logic                     WE_IN,
    input  logic                     FLUSH,
    output logic                     OUT_VALID,
    input  logic                     OUT_READY,
    output logic [WIDTH-1:0]         WD,
    output logic [ADDR_W-1:0]        WA,
    output logic                     WE,
    output logic                     FWD_VALID
);

    slot_state_e      state;
    logic [WIDTH-1:0] sel_data;
    logic [WIDTH-1:0] aligned;
    logic [WIDTH-1:0] next_wd;
    logic             is_load;
    logic             next_we;
    logic             xfer_in;

    // Out-of-range selects (non power-of-two NUM_SRC) fall through to 0.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_SRC; i++)
            if (int'(RF_WR_SEL) == i) sel_data = SRC[i*WIDTH +: WIDTH];
    end

    load_align #(.WIDTH(WIDTH)) u_align (
        .raw      (sel_data),
        .mem_size (MEM_SIZE),
        .mem_sign (MEM_SIGN),
        .byte_off (BYTE_OFF),
        .data     (aligned)
    );

    assign is_load = (int'(RF_WR_SEL) == LOAD_SRC);
    assign next_wd = is_load ? aligned : sel_data;
    // Writes to x0 are dropped here so neither the register file nor the
    // forwarding logic ever sees them; data/address still captured.
    assign next_we = WE_IN && (WA_IN != '0);

    assign OUT_VALID = (state == SLOT_FULL);
    assign IN_READY  = !OUT_VALID || OUT_READY;
    assign xfer_in   = IN_VALID && IN_READY;
    assign FWD_VALID = OUT_VALID && WE;

    always_ff @(posedge CLK) begin
        if (RST || FLUSH) begin
            state <= SLOT_EMPTY;
            WD    <= '0;
            WA    <= '0;
            WE    <= 1'b0;
        end else if (xfer_in) begin
            // Covers both EMPTY fill and FULL replace-on-drain.
            state <= SLOT_FULL;
            WD    <= next_wd;
            WA    <= WA_IN;
            WE    <= next_we;
        end else if (OUT_READY) begin
            state <= SLOT_EMPTY;
        end
    end

endmodule

// File: tb/tb_wb_stage_reg.sv
module tb_wb_stage_reg;

    logic         CLK = 1'b0;
    logic         RST, IN_VALID, OUT_READY, FLUSH, WE_IN, MEM_SIGN;
    logic [127:0] SRC;
    logic [1:0]   RF_WR_SEL, MEM_SIZE, BYTE_OFF;
    logic [4:0]   WA_IN;
    logic         IN_READY, OUT_VALID, WE, FWD_VALID;
    logic [31:0]  WD;
    logic [4:0]   WA;
    logic         IN_READY3, OUT_VALID3, WE3, FWD_VALID3;
    logic [31:0]  WD3;
    logic [4:0]   WA3;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] wd;
        logic [4:0]  wa;
        logic        we;
    } exp_t;
    exp_t sb[$];

    always #5 CLK = ~CLK;

    wb_stage_reg dut (
        .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .SRC(SRC), .RF_WR_SEL(RF_WR_SEL), .MEM_SIZE(MEM_SIZE),
        .MEM_SIGN(MEM_SIGN), .BYTE_OFF(BYTE_OFF), .WA_IN(WA_IN),
        .WE_IN(WE_IN), .FLUSH(FLUSH), .OUT_VALID(OUT_VALID),
        .OUT_READY(OUT_READY), .WD(WD), .WA(WA), .WE(WE),
        .FWD_VALID(FWD_VALID)
    );

    wb_stage_reg #(.NUM_SRC(3)) dut3 (
        .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY3),
        .SRC(SRC[95:0]), .RF_WR_SEL(RF_WR_SEL), .MEM_SIZE(MEM_SIZE),
        .MEM_SIGN(MEM_SIGN), .BYTE_OFF(BYTE_OFF), .WA_IN(WA_IN),
        .WE_IN(WE_IN), .FLUSH(FLUSH), .OUT_VALID(OUT_VALID3),
        .OUT_READY(OUT_READY), .WD(WD3), .WA(WA3), .WE(WE3),
        .FWD_VALID(FWD_VALID3)
    );

    // Reference write data for the 4-source DUT from current inputs.
    function automatic logic [31:0] model_wd();
        logic [31:0] d, b;
        d = SRC[int'(RF_WR_SEL)*32 +: 32];
        if (RF_WR_SEL != 2'd1) return d;
        case (MEM_SIZE)
            2'd0: begin
                b = (d >> (int'(BYTE_OFF) * 8)) & 32'hFF;
                if (MEM_SIGN && b[7]) b = b | 32'hFFFF_FF00;
                return b;
            end
            2'd1: begin
                b = (d >> (int'(BYTE_OFF[1]) * 16)) & 32'hFFFF;
                if (MEM_SIGN && b[15]) b = b | 32'hFFFF_0000;
                return b;
            end
            default: return d;
        endcase
    endfunction

    // Advance one clock, keeping the scoreboard in step with the slot.
    task automatic step();
        exp_t e;
        logic xfer, consumed;
        #1;
        xfer     = IN_VALID && IN_READY;
        consumed = OUT_VALID && OUT_READY;
        e.wd = model_wd();
        e.wa = WA_IN;
        e.we = WE_IN && (WA_IN != 5'd0);
        @(posedge CLK);
        #1;
        if (RST || FLUSH) sb.delete();
        else begin
            if (consumed && sb.size() != 0) void'(sb.pop_front());
            if (xfer) sb.push_back(e);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1; IN_VALID = 1'b1; OUT_READY = 1'b0; FLUSH = 1'b0;
        SRC = '1; RF_WR_SEL = 2'd3; MEM_SIZE = 2'd2; MEM_SIGN = 1'b0;
        BYTE_OFF = 2'd0; WA_IN = 5'd3; WE_IN = 1'b1;
        step(); step();
        checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b exp 0", OUT_VALID); end
        checks++; if (WD !== 32'h0) begin errors++; $display("FAIL reset_wd: got %h exp 0", WD); end
        checks++; if (WE !== 1'b0 || FWD_VALID !== 1'b0) begin errors++; $display("FAIL reset_we: got %b/%b exp 0/0", WE, FWD_VALID); end
        checks++; if (IN_READY !== 1'b1) begin errors++; $display("FAIL reset_in_ready_during: got %b exp 1", IN_READY); end
        RST = 1'b0; IN_VALID = 1'b0;
        step();
        checks++; if (IN_READY !== 1'b1 || OUT_VALID !== 1'b0) begin errors++; $display("FAIL reset_release: in_ready %b out_valid %b exp 1/0", IN_READY, OUT_VALID); end
    endtask

    task automatic test_select();
        SRC = {32'h3, 32'h2, 32'h1, 32'h0};
        RF_WR_SEL = 2'd2; WA_IN = 5'd5; WE_IN = 1'b1; OUT_READY = 1'b1;
        IN_VALID = 1'b1;
        step();
        IN_VALID = 1'b0;
        checks++; if (sb.size() == 0 || WD !== 32'h2 || WD !== sb[0].wd) begin errors++; $display("FAIL sel_wd: got %h exp 2", WD); end
        checks++; if (WA !== 5'd5 || WE !== 1'b1 || FWD_VALID !== 1'b1 || OUT_VALID !== 1'b1) begin errors++; $display("FAIL sel_ctrl: wa %0d we %b fwd %b vld %b exp 5/1/1/1", WA, WE, FWD_VALID, OUT_VALID); end
        WA_IN = 5'd0; IN_VALID = 1'b1;
        step();
        IN_VALID = 1'b0;
        checks++; if (sb.size() == 0 || WE !== sb[0].we || WE !== 1'b0 || FWD_VALID !== 1'b0) begin errors++; $display("FAIL sel_x0: we %b fwd %b exp 0/0", WE, FWD_VALID); end
        checks++; if (WA !== 5'd0 || WD !== 32'h2) begin errors++; $display("FAIL sel_x0_capture: wa %0d wd %h exp 0/2", WA, WD); end
        step();
        checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL sel_drain: got %b exp 0", OUT_VALID); end
    endtask

    task automatic test_load();
        logic [1:0]  sz [5] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd3};
        logic [1:0]  of [5] = '{2'd3, 2'd1, 2'd2, 2'd3, 2'd0};
        logic        sg [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [31:0] ex [5] = '{32'hFFFF_FF80, 32'h0000_007F, 32'hFFFF_80FF,
                                32'hFFFF_80FF, 32'h80FF_7F01};
        SRC = {32'h3, 32'h2, 32'h80FF_7F01, 32'h0};
        RF_WR_SEL = 2'd1; WA_IN = 5'd10; WE_IN = 1'b1; OUT_READY = 1'b1;
        for (int k = 0; k < 5; k++) begin
            MEM_SIZE = sz[k]; BYTE_OFF = of[k]; MEM_SIGN = sg[k];
            IN_VALID = 1'b1;
            step();
            IN_VALID = 1'b0;
            checks++; if (sb.size() == 0 || WD !== ex[k] || WD !== sb[0].wd) begin errors++; $display("FAIL load_%0d: got %h exp %h", k, WD, ex[k]); end
            step();
        end
        MEM_SIZE = 2'd2;
    endtask

    task automatic test_backpressure();
        SRC = {32'hA5A5, 32'h2, 32'h1, 32'h0};
        RF_WR_SEL = 2'd3; WA_IN = 5'd7; WE_IN = 1'b1;
        OUT_READY = 1'b0; IN_VALID = 1'b1;
        step();
        SRC[127:96] = 32'h5A5A;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (OUT_VALID !== 1'b1 || WD !== 32'hA5A5 || sb.size() == 0 || WD !== sb[0].wd) begin errors++; $display("FAIL bp_hold_%0d: vld %b wd %h exp 1/a5a5", k, OUT_VALID, WD); end
            checks++; if (IN_READY !== 1'b0) begin errors++; $display("FAIL bp_in_ready_%0d: got %b exp 0", k, IN_READY); end
        end
        OUT_READY = 1'b1;
        #1;
        checks++; if (IN_READY !== 1'b1) begin errors++; $display("FAIL bp_comb_ready: got %b exp 1", IN_READY); end
        step();
        checks++; if (OUT_VALID !== 1'b1 || WD !== 32'h5A5A || sb.size() == 0 || WD !== sb[0].wd) begin errors++; $display("FAIL bp_release: vld %b wd %h exp 1/5a5a", OUT_VALID, WD); end
        IN_VALID = 1'b0;
        step();
    endtask

    task automatic test_flush();
        RF_WR_SEL = 2'd3; IN_VALID = 1'b1; OUT_READY = 1'b1;
        step();
        OUT_READY = 1'b0; FLUSH = 1'b1;
        step();
        FLUSH = 1'b0; IN_VALID = 1'b0;
        checks++; if (OUT_VALID !== 1'b0 || WD !== 32'h0 || WE !== 1'b0 || WA !== 5'd0) begin errors++; $display("FAIL flush: vld %b wd %h we %b wa %0d exp all 0", OUT_VALID, WD, WE, WA); end
    endtask

    task automatic test_reset_stall();
        RF_WR_SEL = 2'd3; IN_VALID = 1'b1; OUT_READY = 1'b0;
        step();
        IN_VALID = 1'b0;
        step();
        RST = 1'b1;
        step();
        RST = 1'b0;
        checks++; if (OUT_VALID !== 1'b0 || WE !== 1'b0 || FWD_VALID !== 1'b0) begin errors++; $display("FAIL reset_stall: vld %b we %b fwd %b exp 0", OUT_VALID, WE, FWD_VALID); end
        OUT_READY = 1'b1;
    endtask

    task automatic test_out_of_range();
        SRC = {32'h1234, 32'h2, 32'h1, 32'h0};
        RF_WR_SEL = 2'd3; WA_IN = 5'd9; IN_VALID = 1'b1; OUT_READY = 1'b1;
        step();
        IN_VALID = 1'b0;
        checks++; if (OUT_VALID3 !== 1'b1 || WD3 !== 32'h0) begin errors++; $display("FAIL oor_3src: vld %b wd %h exp 1/0", OUT_VALID3, WD3); end
        checks++; if (sb.size() == 0 || WD !== sb[0].wd || WD !== 32'h1234) begin errors++; $display("FAIL oor_4src: wd %h exp 1234", WD); end
        step();
    endtask

    task automatic test_back_to_back();
        int outs = 0;
        RF_WR_SEL = 2'd0; WE_IN = 1'b1; OUT_READY = 1'b1;
        for (int k = 0; k < 8; k++) begin
            SRC[31:0] = 32'h100 + k;
            WA_IN = 5'(k + 1);
            IN_VALID = 1'b1;
            step();
            if (OUT_VALID === 1'b1) outs++;
            checks++; if (OUT_VALID !== 1'b1 || sb.size() == 0 || WD !== sb[0].wd || WA !== sb[0].wa) begin errors++; $display("FAIL b2b_%0d: vld %b wd %h wa %0d exp 1/%h/%0d", k, OUT_VALID, WD, WA, 32'h100 + k, k + 1); end
        end
        IN_VALID = 1'b0;
        step();
        checks++; if (outs != 8 || OUT_VALID !== 1'b0) begin errors++; $display("FAIL b2b_count: outs %0d vld %b exp 8/0", outs, OUT_VALID); end
    endtask

    initial begin
        test_reset();
        test_select();
        test_load();
        test_backpressure();
        test_flush();
        test_reset_stall();
        test_out_of_range();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
